// File: rtl/program_rom_loader.sv
// Run-time loadable instruction memory for the lab CPU.
// A loader FSM fills the array; fetches return registered words.
module program_rom_loader #(
  parameter int          DATA_W        = 28,
  parameter int          ADDR_W        = 16,
  parameter int          DEPTH         = 256,
  parameter logic [DATA_W-1:0] DEFAULT_INSTR = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iLoadStart,
  input  logic [ADDR_W-1:0] iLoadCount,
  input  logic              iLoadValid,
  input  logic [DATA_W-1:0] iLoadData,
  output logic              oLoadReady,
  output logic              oLoadDone,
  input  logic              iFetchEn,
  input  logic [ADDR_W-1:0] iAddress,
  output logic [DATA_W-1:0] oInstruction,
  output logic              oInstrValid,
  output logic              oBusy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] eff_count;
  logic [CNT_W-1:0] load_count;
  logic [CNT_W-1:0] prog_len;
  logic             accept;
  logic             last_word;
  logic             fetch_hit;
  logic             addr_unused;

  // A zero or oversized count means "fill the whole array".
  always_comb begin
    eff_count = {1'b0, iLoadCount};
    if (iLoadCount == '0 ||
        {1'b0, iLoadCount} > CNT_W'(DEPTH))
      eff_count = CNT_W'(DEPTH);
  end

  // A restart in the same cycle wins over the word on the bus.
  assign accept    = (state == LOAD) && iLoadValid
                     && !iLoadStart;
  assign last_word = accept &&
                     (CNT_W'(wr_ptr) == load_count - CNT_W'(1));

  assign fetch_hit = (state == RUN) &&
                     ({1'b0, iAddress} < prog_len);
  assign rd_idx      = IDX_W'(iAddress);
  assign addr_unused = ^iAddress;

  assign oLoadReady = (state == LOAD);
  assign oBusy      = (state == LOAD);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (iLoadStart) state_nx = LOAD;
      LOAD: begin
        if (iLoadStart)     state_nx = LOAD;
        else if (last_word) state_nx = RUN;
      end
      RUN:  if (iLoadStart) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      load_count   <= '0;
      prog_len     <= '0;
      oLoadDone    <= 1'b0;
      oInstruction <= DEFAULT_INSTR;
      oInstrValid  <= 1'b0;
    end else begin
      state <= state_nx;
      if (iLoadStart) begin
        wr_ptr     <= '0;
        load_count <= eff_count;
        prog_len   <= '0;
        oLoadDone  <= 1'b0;
      end else if (last_word) begin
        prog_len  <= load_count;
        oLoadDone <= 1'b1;
      end else if (accept) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
      end
      oInstrValid <= iFetchEn;
      if (iFetchEn)
        oInstruction <= fetch_hit ? mem[rd_idx]
                                  : DEFAULT_INSTR;
    end
  end

  always_ff @(posedge Clock) begin
    if (accept)
      mem[wr_ptr] <= iLoadData;
  end

endmodule

// File: tb/tb_program_rom_loader.sv
// Bench for program_rom_loader: directed loads plus random traffic
// checked every cycle against a queue-based program model.
module tb_program_rom_loader;

  localparam int DW = 28;
  localparam int AW = 16;
  localparam int DP = 8;
  localparam logic [DW-1:0] DEF = 28'hDEAD0BE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_count = '0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          ready, done, busy;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] instr;
  logic          ivalid;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: program contents and whether a load is in flight.
  bit          m_loading, m_done;
  int          m_target, m_plen;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_prog[DP];
  logic [DW-1:0] m_instr;
  bit          m_ivalid;

  program_rom_loader #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP),
    .DEFAULT_INSTR(DEF)
  ) dut (
    .Clock(clk), .Reset(rst),
    .iLoadStart(load_start), .iLoadCount(load_count),
    .iLoadValid(load_valid), .iLoadData(load_data),
    .oLoadReady(ready), .oLoadDone(done),
    .iFetchEn(fetch_en), .iAddress(addr),
    .oInstruction(instr), .oInstrValid(ivalid),
    .oBusy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    if (rst) begin
      m_loading = 0; m_done = 0; m_plen = 0;
      m_instr = DEF; m_ivalid = 0; m_q.delete();
    end else begin
      if (fetch_en)
        m_instr = (m_done && int'(addr) < m_plen)
                  ? m_prog[addr] : DEF;
      m_ivalid = fetch_en;
      if (load_start) begin
        m_loading = 1;
        m_target = (load_count == 0 || load_count > DP)
                   ? DP : int'(load_count);
        m_q.delete();
        m_done = 0; m_plen = 0;
      end else if (m_loading && load_valid) begin
        m_q.push_back(load_data);
        if (m_q.size() == m_target) begin
          for (int i = 0; i < m_target; i++)
            m_prog[i] = m_q[i];
          m_plen = m_target;
          m_done = 1;
          m_loading = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("instr", 32'(instr), 32'(m_instr));
    chk("ivalid", 32'(ivalid), 32'(m_ivalid));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_loading));
    chk("ready", 32'(ready), 32'(m_loading));
  endtask

  task automatic start(input int cnt);
    load_start = 1; load_count = AW'(cnt);
    cyc();
    load_start = 0;
  endtask

  task automatic word(input logic [DW-1:0] d);
    load_valid = 1; load_data = d;
    cyc();
    load_valid = 0;
  endtask

  task automatic fetch(input int a);
    fetch_en = 1; addr = AW'(a);
    cyc();
    fetch_en = 0;
  endtask

  initial begin
    cyc(); cyc();
    rst = 0;
    fetch(0);
    chk("rst_fetch", 32'(instr), 32'(DEF));
    chk("rst_done", 32'(done), 0);

    // Count 3, back-to-back; fetch alongside the last word.
    start(3);
    word(28'h1000001);
    word(28'h2000002);
    fetch_en = 1; addr = 0;
    word(28'h3000003);
    fetch_en = 0;
    chk("last_fetch_def", 32'(instr), 32'(DEF));
    chk("done3", 32'(done), 1);
    for (int i = 0; i < 4; i++) fetch(i);
    chk("fetch3_def", 32'(instr), 32'(DEF));

    // Count 4 with gaps; fetch in the same cycle as restart.
    fetch_en = 1; addr = 1;
    start(4);
    fetch_en = 0;
    chk("start_fetch", 32'(instr), 32'h2000002);
    for (int i = 0; i < 4; i++) begin
      cyc();
      word(28'hA00 + DW'(i));
    end
    for (int i = 0; i < 5; i++) fetch(i);

    // Zero count fills the whole array.
    start(0);
    for (int i = 0; i < DP; i++) begin
      chk("busy_fill", 32'(busy), 1);
      word(28'hB00 + DW'(i));
    end
    chk("done_fill", 32'(done), 1);
    for (int i = 0; i <= DP; i++) fetch(i);

    // Restart mid-load, with a word on the bus that cycle.
    start(5);
    word(28'hC01);
    word(28'hC02);
    load_valid = 1; load_data = 28'hC0F;
    start(2);
    load_valid = 0;
    word(28'hD01);
    word(28'hD02);
    for (int i = 0; i < 3; i++) fetch(i);
    chk("restart_f2", 32'(instr), 32'(DEF));

    // Reset mid-load, then hold behaviour.
    start(3);
    word(28'hE01);
    rst = 1; cyc(); rst = 0;
    fetch(0);
    chk("rst_mid", 32'(instr), 32'(DEF));
    cyc();
    chk("hold_valid", 32'(ivalid), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      load_start = ($urandom_range(0, 29) == 0);
      load_count = AW'($urandom_range(0, 11));
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = DW'($urandom);
      fetch_en   = ($urandom_range(0, 1) == 1);
      addr       = AW'($urandom_range(0, 11));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
